// File: rtl/data_mem_unit.sv
// Byte-addressable data memory for the load/store path: byte/half/word, sign/zero-extended loads, error flagging.
// Latency: response valid WAIT_CYCLES+1 edges after acceptance; one request in flight at a time.
// Backpressure: req_ready only in IDLE; RESP is held with stable data until resp_ready.
module data_mem_unit #(
    parameter int MEM_BYTES   = 65536,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);
    localparam int                  MEM_AW    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } stateT;

    // Only the in-range address bits are kept; the range check is resolved at acceptance.
    typedef struct packed {
        logic              write;
        logic [MEM_AW-1:0] addr;
        logic [1:0]        size;
        logic              isUnsigned;
        logic [31:0]       wdata;
        logic              error;
    } reqT;

    function automatic logic [2:0] sizeBytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic [7:0]          mem [MEM_BYTES];

    stateT               stateQ;
    stateT               stateD;
    logic [3:0]          wcntQ;
    reqT                 reqQ;
    logic [31:0]         respRdataQ;
    logic                respErrorQ;

    logic                accept;
    logic                accessDone;
    logic                reqErr;
    logic [ADDR_WIDTH:0] reqEnd;
    logic [2:0]          nbytesQ;
    logic [MEM_AW-1:0]   byteIdx [4];
    logic [31:0]         rawWord;
    logic [31:0]         loadData;

    // Error decode on the incoming request; end address is one bit wider so it never wraps.
    always_comb begin
        reqEnd = {1'b0, req_addr} + (ADDR_WIDTH+1)'(sizeBytes(req_size));
        reqErr = 1'b0;
        if (req_size == 2'd3)                               reqErr = 1'b1;
        if (req_size == 2'd1 && req_addr[0])                reqErr = 1'b1;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00)     reqErr = 1'b1;
        if (reqEnd > MEM_LIMIT)                             reqErr = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= S_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next state
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            S_IDLE:  if (req_valid)        stateD = S_WAIT;
            S_WAIT:  if (wcntQ == 4'd0)    stateD = S_RESP;
            S_RESP:  if (resp_ready)       stateD = S_IDLE;
            default:                       stateD = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready  = (stateQ == S_IDLE) && !reset;
        resp_valid = (stateQ == S_RESP);
        accessDone = (stateQ == S_WAIT) && (wcntQ == 4'd0);
        accept     = req_valid && req_ready;
    end

    assign nbytesQ = sizeBytes(reqQ.size);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byteIdx[k] = reqQ.addr + MEM_AW'(k);
        end
    end

    assign rawWord = {mem[byteIdx[3]], mem[byteIdx[2]], mem[byteIdx[1]], mem[byteIdx[0]]};

    always_comb begin
        case (reqQ.size)
            2'd0:    loadData = reqQ.isUnsigned ? {24'h0, rawWord[7:0]}
                                                : {{24{rawWord[7]}}, rawWord[7:0]};
            2'd1:    loadData = reqQ.isUnsigned ? {16'h0, rawWord[15:0]}
                                                : {{16{rawWord[15]}}, rawWord[15:0]};
            default: loadData = rawWord;
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wcntQ      <= 4'd0;
            reqQ       <= '0;
            respRdataQ <= 32'd0;
            respErrorQ <= 1'b0;
        end else begin
            if (accept) begin
                reqQ  <= '{write:      req_write,
                           addr:       req_addr[MEM_AW-1:0],
                           size:       req_size,
                           isUnsigned: req_unsigned,
                           wdata:      req_wdata,
                           error:      reqErr};
                wcntQ <= WAIT_INIT;
            end else if (stateQ == S_WAIT && wcntQ != 4'd0) begin
                wcntQ <= wcntQ - 4'd1;
            end

            if (accessDone) begin
                respRdataQ <= (reqQ.write || reqQ.error) ? 32'd0 : loadData;
                respErrorQ <= reqQ.error;
            end else if (stateQ == S_RESP && resp_ready) begin
                respRdataQ <= 32'd0;
                respErrorQ <= 1'b0;
            end
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && accessDone && reqQ.write && !reqQ.error) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(nbytesQ)) begin
                    mem[byteIdx[k]] <= reqQ.wdata[8*k +: 8];
                end
            end
        end
    end

    assign resp_rdata = respRdataQ;
    assign resp_error = respErrorQ;

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised, handshake-driven data memory for the CPU load/store path, the next-generation data memory of the core. It supports byte, halfword and word accesses, signed or unsigned load extension, little-endian byte order, configurable wait states, and alignment and range error reporting. It accepts one request at a time through a valid/ready handshake and returns one response through a valid/ready handshake. This lets the pipeline stall on memory latency instead of assuming a combinational read.

## Interface
Parameters:
- MEM_BYTES, 65536, memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- ADDR_WIDTH, 32, request address width.
- WAIT_CYCLES, 2, extra wait states before the access completes; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (error).
- req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- req_wdata  in  32  store data; the low 8, 16 or 32 bits are used according to req_size.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request was rejected: misaligned, out of range or reserved size.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch write, addr, size, unsigned and wdata; compute the error flag; load wcnt=WAIT_CYCLES; go to WAIT.
- WAIT:
  - req_ready=0.
  - If wcnt!=0: decrement wcnt.
  - Else: perform the access, register resp_rdata and resp_error, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - On resp_ready: go to IDLE and clear resp_valid.
  - A new request is never accepted in the same cycle a response is accepted.
- Error conditions (any one of these sets the error flag):
  - size==3.
  - Halfword with addr[0]!=0.
  - Word with addr[1:0]!=0.
  - addr+nbytes > MEM_BYTES, computed without truncation at ADDR_WIDTH+1 bits.
- Errored request: no memory write, resp_rdata=0, resp_error=1. Latency is identical to a good request.
- Store:
  - Write nbytes little-endian: mem[a]=wdata[7:0], mem[a+1]=wdata[15:8], and so on.
  - resp_rdata=0, resp_error=0.
- Load:
  - Assemble {mem[a+3],mem[a+2],mem[a+1],mem[a]} truncated to the access size.
  - Extend to 32 bits: sign-extend from bit 7 or 15 unless req_unsigned; word loads are never extended.
- Memory contents are not initialised by reset. Contents are undefined until written, and the bench preloads memory through hierarchical access.

## Timing
- Reset, while asserted and on the cycle after:
  - State = IDLE, wcnt=0.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - req_ready=0 while reset is high, and 1 from the first cycle after reset deasserts.
- Latency: acceptance at edge E0 gives resp_valid=1 after edge E0+WAIT_CYCLES+1.
  - Example: WAIT_CYCLES=2 gives a response 3 cycles after acceptance.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles when resp_ready is tied high.
- The memory write commits on the same edge that enters RESP.
- Reset at or before that edge aborts the request: no write, no response.
- Reset during RESP drops the response.
- req_* inputs are ignored outside IDLE. Inputs changing after acceptance do not affect the in-flight request.
- resp_ready held low keeps RESP indefinitely with outputs stable.
- Address arithmetic a+1..a+3 never wraps. The range check rejects such a request before any access.

## Test plan
- Reset, then word store 0xDEADBEEF at 0x10 with resp_ready=1, WAIT_CYCLES=2 -> resp_valid rises 3 cycles after acceptance, resp_error=0, resp_rdata=0; then word load at 0x10 -> 0xDEADBEEF.
- Byte load at 0x10 signed -> 0xFFFFFFEF; unsigned -> 0x000000EF; halfword load at 0x12 signed -> 0xFFFFDEAD; unsigned -> 0x0000DEAD.
- Word store at 0x11, halfword load at 0x13, req_size=3, and word load at MEM_BYTES-2 -> each gives resp_error=1 and resp_rdata=0; a word load at 0x10 afterwards still returns 0xDEADBEEF (no corruption).
- Hold resp_ready=0 for 5 cycles in RESP while toggling req_* -> resp_valid, resp_rdata and resp_error stay stable; req_ready=0; no second request is accepted.
- Assert reset during WAIT of a word store 0x12345678 to 0x20 -> no response, outputs 0, req_ready=1 one cycle after release; a load at 0x20 returns the previously written value.
- Repeat the first and second scenarios with WAIT_CYCLES=0 -> response one cycle after acceptance with identical data.
